// File: rtl/pps_div_regbank.sv
// Double-buffered PPS divider configuration bank: host writes land in shadow storage and move to the active outputs on the first PPS edge after a commit.
// Build option: define PPS_REGBANK_READ_ACTIVE_EN to make channel offsets read back the active copy instead of the shadow.
module pps_div_regbank #(
    parameter logic [7:0] BASE_ADDR = 8'h10,
    parameter int         NUM_CH    = 4,
    parameter int         CH_STRIDE = 16
) (
    input  logic                  i_clk_10,
    input  logic                  i_rst,
    input  logic [7:0]            i_addr,
    input  logic [7:0]            i_data,
    input  logic                  i_wr,
    input  logic                  i_pps,
    output logic [7:0]            o_data,
    output logic [NUM_CH-1:0]     o_periodic_true,
    output logic [8*NUM_CH-1:0]   o_div_number,
    output logic [32*NUM_CH-1:0]  o_phase_us,
    output logic [8*NUM_CH-1:0]   o_width_us,
    output logic [8*NUM_CH-1:0]   o_start,
    output logic [8*NUM_CH-1:0]   o_stop,
    output logic [NUM_CH-1:0]     o_pending,
    output logic                  o_commit_stb
);

    localparam int         NUM_REGS = 9;
    localparam logic [7:0] G_ADDR   = 8'(int'(BASE_ADDR) + CH_STRIDE * NUM_CH);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } ch_state_e;

    // Register byte layout per channel: 0 CTRL, 1 DIV, 2..5 PHASE (LSB first), 6 WIDTH, 7 START, 8 STOP.
    logic [7:0] shadow_q [NUM_CH][NUM_REGS];
    logic [7:0] shadow_d [NUM_CH][NUM_REGS];
    logic [7:0] active_q [NUM_CH][NUM_REGS];
    logic [7:0] active_d [NUM_CH][NUM_REGS];
    ch_state_e  state_q  [NUM_CH];
    ch_state_e  state_d  [NUM_CH];

    logic       pps_q, pps_d;
    logic [7:0] pps_cnt_q, pps_cnt_d;
    logic [7:0] o_data_q, o_data_d;
    logic       commit_stb_q, commit_stb_d;

    logic [7:0]        rel_addr;
    logic [3:0]        ch_sel;
    logic [3:0]        reg_sel;
    logic              ch_hit;
    logic              commit_hit;
    logic              cnt_hit;
    logic              pps_edge;
    logic              commit_wr;
    logic              cnt_clr;
    logic [NUM_CH-1:0] pending;

    always_comb begin
        rel_addr   = i_addr - BASE_ADDR;
        ch_sel     = rel_addr[7:4];
        reg_sel    = rel_addr[3:0];
        ch_hit     = (i_addr >= BASE_ADDR) && (int'(ch_sel) < NUM_CH) && (reg_sel <= 4'd8);
        commit_hit = (i_addr == G_ADDR);
        cnt_hit    = (i_addr == G_ADDR + 8'd1);
        pps_edge   = i_pps & ~pps_q;
        commit_wr  = i_wr & commit_hit;
        cnt_clr    = i_wr & cnt_hit;
        for (int c = 0; c < NUM_CH; c++) begin
            pending[c] = (state_q[c] == ST_PENDING);
        end
    end

    // Commit FSMs, shadow writes and counter; active copies take the pre-write shadow.
    always_comb begin
        shadow_d     = shadow_q;
        active_d     = active_q;
        state_d      = state_q;
        pps_d        = i_pps;
        pps_cnt_d    = pps_cnt_q;
        commit_stb_d = 1'b0;

        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (i_wr && ch_hit && (ch_sel == 4'(c)) && (reg_sel == 4'(r))) begin
                    shadow_d[c][r] = i_data;
                end
            end
        end

        for (int c = 0; c < NUM_CH; c++) begin
            case (state_q[c])
                ST_IDLE: begin
                    if (commit_wr && i_data[c]) begin
                        state_d[c] = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (pps_edge) begin
                        active_d[c]  = shadow_q[c];
                        commit_stb_d = 1'b1;
                        state_d[c]   = (commit_wr && i_data[c]) ? ST_PENDING : ST_IDLE;
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase
        end

        if (cnt_clr) begin
            pps_cnt_d = 8'h00;
        end else if (pps_edge) begin
            pps_cnt_d = pps_cnt_q + 8'd1;
        end
    end

    // Read mux works from current register values, so a same-cycle write reads back old data.
    always_comb begin
        o_data_d = 8'h00;
        if (ch_hit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    if ((ch_sel == 4'(c)) && (reg_sel == 4'(r))) begin
`ifdef PPS_REGBANK_READ_ACTIVE_EN
                        o_data_d = active_q[c][r];
`else
                        o_data_d = shadow_q[c][r];
`endif
                    end
                end
            end
        end else if (commit_hit) begin
            o_data_d[NUM_CH-1:0] = pending;
        end else if (cnt_hit) begin
            o_data_d = pps_cnt_q;
        end
    end

    always_ff @(posedge i_clk_10) begin
        if (i_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
                for (int r = 0; r < NUM_REGS; r++) begin
                    shadow_q[c][r] <= 8'h00;
                    active_q[c][r] <= 8'h00;
                end
            end
            pps_q        <= 1'b0;
            pps_cnt_q    <= 8'h00;
            o_data_q     <= 8'h00;
            commit_stb_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            state_q      <= state_d;
            pps_q        <= pps_d;
            pps_cnt_q    <= pps_cnt_d;
            o_data_q     <= o_data_d;
            commit_stb_q <= commit_stb_d;
        end
    end

    always_comb begin
        o_periodic_true = '0;
        o_div_number    = '0;
        o_phase_us      = '0;
        o_width_us      = '0;
        o_start         = '0;
        o_stop          = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            o_periodic_true[c]  = active_q[c][0][0];
            o_div_number[8*c +: 8] = active_q[c][1];
            o_phase_us[32*c +: 32] = {active_q[c][5], active_q[c][4], active_q[c][3], active_q[c][2]};
            o_width_us[8*c +: 8]   = active_q[c][6];
            o_start[8*c +: 8]      = active_q[c][7];
            o_stop[8*c +: 8]       = active_q[c][8];
        end
    end

    assign o_data       = o_data_q;
    assign o_pending    = pending;
    assign o_commit_stb = commit_stb_q;

endmodule

// File: tb/tb_pps_div_regbank.sv
// Self-checking bench for pps_div_regbank: directed commit/PPS scenarios plus a randomized shadow/commit pass.
module tb_pps_div_regbank;

  localparam int NUM_CH = 4;
  localparam logic [7:0] G_ADDR = 8'h50;
  localparam logic [7:0] CNT_ADDR = 8'h51;

  logic                  i_clk_10;
  logic                  i_rst;
  logic [7:0]            i_addr;
  logic [7:0]            i_data;
  logic                  i_wr;
  logic                  i_pps;
  logic [7:0]            o_data;
  logic [NUM_CH-1:0]     o_periodic_true;
  logic [8*NUM_CH-1:0]   o_div_number;
  logic [32*NUM_CH-1:0]  o_phase_us;
  logic [8*NUM_CH-1:0]   o_width_us;
  logic [8*NUM_CH-1:0]   o_start;
  logic [8*NUM_CH-1:0]   o_stop;
  logic [NUM_CH-1:0]     o_pending;
  logic                  o_commit_stb;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_ch3 [9];

  pps_div_regbank #(
    .BASE_ADDR(8'h10),
    .NUM_CH(NUM_CH),
    .CH_STRIDE(16)
  ) dut (
    .i_clk_10(i_clk_10),
    .i_rst(i_rst),
    .i_addr(i_addr),
    .i_data(i_data),
    .i_wr(i_wr),
    .i_pps(i_pps),
    .o_data(o_data),
    .o_periodic_true(o_periodic_true),
    .o_div_number(o_div_number),
    .o_phase_us(o_phase_us),
    .o_width_us(o_width_us),
    .o_start(o_start),
    .o_stop(o_stop),
    .o_pending(o_pending),
    .o_commit_stb(o_commit_stb)
  );

  // clock / reset
  initial i_clk_10 = 1'b0;
  always #50 i_clk_10 = ~i_clk_10;

  task automatic tick();
    @(posedge i_clk_10);
    @(negedge i_clk_10);
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    i_addr = addr;
    i_data = data;
    i_wr = 1'b1;
    tick();
    i_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    i_addr = addr;
    i_wr = 1'b0;
    exp_q.push_back(exp);
    tick();
    check_eq(tag, {24'h0, o_data}, {24'h0, exp_q.pop_front()});
  endtask

  task automatic pps_pulse();
    i_pps = 1'b1;
    tick();
    i_pps = 1'b0;
    tick();
  endtask

  initial begin
    i_rst = 1'b1;
    i_addr = 8'h00;
    i_data = 8'h00;
    i_wr = 1'b0;
    i_pps = 1'b0;
    @(negedge i_clk_10);
    tick();
    tick();
    i_rst = 1'b0;

    // reset state
    check_eq("rst_div", o_div_number, 32'h0);
    check_eq("rst_phase0", o_phase_us[31:0], 32'h0);
    check_eq("rst_pending", {28'h0, o_pending}, 32'h0);
    check_eq("rst_stb", {31'h0, o_commit_stb}, 32'h0);
    check_eq("rst_periodic", {28'h0, o_periodic_true}, 32'h0);
    rd("rst_rd_10", 8'h10, 8'h00);
    rd("rst_rd_15", 8'h15, 8'h00);
    rd("rst_rd_cnt", CNT_ADDR, 8'h00);

    // basic commit of channel 0 DIV
    wr(8'h11, 8'h05);
    check_eq("div_before_commit", {24'h0, o_div_number[7:0]}, 32'h0);
    wr(G_ADDR, 8'h01);
    check_eq("pending_ch0", {28'h0, o_pending}, 32'h1);
    check_eq("div_still_old", {24'h0, o_div_number[7:0]}, 32'h0);
    i_pps = 1'b1;
    tick();
    check_eq("div_committed", {24'h0, o_div_number[7:0]}, 32'h5);
    check_eq("pending_cleared", {28'h0, o_pending}, 32'h0);
    check_eq("stb_high", {31'h0, o_commit_stb}, 32'h1);
    i_pps = 1'b0;
    tick();
    check_eq("stb_one_cycle", {31'h0, o_commit_stb}, 32'h0);

    // phase bytes and CTRL periodic bit
    wr(8'h12, 8'h78);
    wr(8'h13, 8'h56);
    wr(8'h14, 8'h34);
    wr(8'h15, 8'h12);
    wr(8'h10, 8'hA5);
    wr(G_ADDR, 8'h01);
    pps_pulse();
    check_eq("phase_ch0", o_phase_us[31:0], 32'h12345678);
    check_eq("periodic_ch0", {28'h0, o_periodic_true}, 32'h1);
    rd("rd_phase_b1", 8'h13, 8'h56);
    rd("rd_ctrl_ch0", 8'h10, 8'hA5);

    // read during write returns the old value
    wr(8'h16, 8'hAA);
    check_eq("rd_during_wr_old", {24'h0, o_data}, 32'h0);
    rd("rd_after_wr", 8'h16, 8'hAA);

    // commit write coincident with an edge waits for the next edge
    wr(8'h21, 8'h9A);
    i_addr = G_ADDR;
    i_data = 8'h02;
    i_wr = 1'b1;
    i_pps = 1'b1;
    tick();
    i_wr = 1'b0;
    i_pps = 1'b0;
    check_eq("late_commit_pending", {28'h0, o_pending}, 32'h2);
    check_eq("late_commit_no_stb", {31'h0, o_commit_stb}, 32'h0);
    check_eq("late_commit_div1_old", {24'h0, o_div_number[15:8]}, 32'h0);
    rd("rd_commit_reg", G_ADDR, 8'h02);
    pps_pulse();
    check_eq("next_edge_div1", {24'h0, o_div_number[15:8]}, 32'h9A);
    check_eq("next_edge_pending", {28'h0, o_pending}, 32'h0);

    // PPS counter wrap and clear-vs-edge priority
    wr(CNT_ADDR, 8'hFF);
    rd("cnt_cleared", CNT_ADDR, 8'h00);
    for (int i = 0; i < 257; i++) pps_pulse();
    rd("cnt_wrap_257", CNT_ADDR, 8'h01);
    i_addr = CNT_ADDR;
    i_data = 8'h33;
    i_wr = 1'b1;
    i_pps = 1'b1;
    tick();
    i_wr = 1'b0;
    i_pps = 1'b0;
    tick();
    rd("cnt_clear_on_edge", CNT_ADDR, 8'h00);

    // reserved / out-of-range decode and read source
    wr(8'h31, 8'hC3);
    wr(8'h1A, 8'hFF);
    wr(8'h52, 8'hFF);
    wr(8'h0F, 8'hFF);
    rd("rd_reserved", 8'h1A, 8'h00);
    rd("rd_out_of_range", 8'h52, 8'h00);
    rd("rd_below_base", 8'h0F, 8'h00);
`ifdef PPS_REGBANK_READ_ACTIVE_EN
    rd("rd_ch2_div", 8'h31, 8'h00);
`else
    rd("rd_ch2_div", 8'h31, 8'hC3);
`endif

    // shadow write to a pending channel in the edge cycle
    wr(G_ADDR, 8'h04);
    i_addr = 8'h31;
    i_data = 8'h11;
    i_wr = 1'b1;
    i_pps = 1'b1;
    tick();
    i_wr = 1'b0;
    i_pps = 1'b0;
    check_eq("edge_wr_active_old", {24'h0, o_div_number[23:16]}, 32'hC3);
    check_eq("edge_wr_pending", {28'h0, o_pending}, 32'h0);
`ifdef PPS_REGBANK_READ_ACTIVE_EN
    rd("edge_wr_readback", 8'h31, 8'hC3);
`else
    rd("edge_wr_readback", 8'h31, 8'h11);
`endif

    // reset abandons a pending commit
    wr(8'h41, 8'h77);
    wr(G_ADDR, 8'h08);
    check_eq("pend_before_rst", {28'h0, o_pending}, 32'h8);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_eq("pend_after_rst", {28'h0, o_pending}, 32'h0);
    check_eq("div_after_rst", o_div_number, 32'h0);
    pps_pulse();
    check_eq("no_commit_after_rst", {24'h0, o_div_number[31:24]}, 32'h0);
    rd("cnt_after_rst", CNT_ADDR, 8'h01);

    // randomized shadow writes to channel 3, then commit
    for (int r = 0; r < 9; r++) model_ch3[r] = 8'h00;
    for (int i = 0; i < 20; i++) begin
      int r;
      logic [7:0] d;
      r = $urandom_range(0, 8);
      d = 8'($urandom_range(0, 255));
      wr(8'h40 + 8'(r), d);
      model_ch3[r] = d;
    end
    for (int r = 0; r < 9; r++) begin
`ifdef PPS_REGBANK_READ_ACTIVE_EN
      rd($sformatf("rand_rd_%0d", r), 8'h40 + 8'(r), 8'h00);
`else
      rd($sformatf("rand_rd_%0d", r), 8'h40 + 8'(r), model_ch3[r]);
`endif
    end
    wr(G_ADDR, 8'hF8);
    check_eq("rand_pending", {28'h0, o_pending}, 32'h8);
    pps_pulse();
    check_eq("rand_periodic", {31'h0, o_periodic_true[3]}, {31'h0, model_ch3[0][0]});
    check_eq("rand_div", {24'h0, o_div_number[31:24]}, {24'h0, model_ch3[1]});
    check_eq("rand_phase", o_phase_us[127:96], {model_ch3[5], model_ch3[4], model_ch3[3], model_ch3[2]});
    check_eq("rand_width", {24'h0, o_width_us[31:24]}, {24'h0, model_ch3[6]});
    check_eq("rand_start", {24'h0, o_start[31:24]}, {24'h0, model_ch3[7]});
    check_eq("rand_stop", {24'h0, o_stop[31:24]}, {24'h0, model_ch3[8]});
    check_eq("rand_other_ch_div", {24'h0, o_div_number[7:0]}, 32'h0);
    rd("rand_commit_rd", G_ADDR, 8'h00);

    // final report
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_q_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
